floor_switch_ctrl: RTL and testbench

Sequences a floor change in the tower game when the player steps onto a staircase tile. It owns the current-floor register and drives the combinational stair-position lookup (floor index in, down/up stair coordinates out). It handshakes with the map loader and then issues a one-cycle spawn command that places the player on the arrival stair of the new floor. It sits between the player-movement logic and the map/render subsystem.

---
 rtl/floor_switch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_floor_switch_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/floor_switch_ctrl.sv
// Floor-change sequencer: stair check, map-load handshake, arrival spawn pulse.
// Optional debug/item teleport enabled by defining FLOOR_TP_EN.
module floor_switch_ctrl #(
   parameter int NUM_FLOORS = 2,
   parameter int FLOOR_W    = 16,
   parameter int COORD_W    = 4
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               step_valid,
   input  logic [COORD_W-1:0] player_x,
   input  logic [COORD_W-1:0] player_y,
   output logic [FLOOR_W-1:0] lookup_floor,
   input  logic [COORD_W-1:0] lk_down_x,
   input  logic [COORD_W-1:0] lk_down_y,
   input  logic [COORD_W-1:0] lk_up_x,
   input  logic [COORD_W-1:0] lk_up_y,
   output logic               map_load_req,
   output logic [FLOOR_W-1:0] map_load_floor,
   input  logic               map_load_done,
`ifdef FLOOR_TP_EN
   input  logic               tp_valid,
   input  logic [FLOOR_W-1:0] tp_floor,
`endif
   output logic [FLOOR_W-1:0] floor,
   output logic               spawn_valid,
   output logic [COORD_W-1:0] spawn_x,
   output logic [COORD_W-1:0] spawn_y,
   output logic               busy
);

   localparam logic [FLOOR_W-1:0] LP_NUM = FLOOR_W'(NUM_FLOORS);
   localparam logic [FLOOR_W-1:0] LP_TOP = FLOOR_W'(NUM_FLOORS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_CHECK,
      S_LOAD,
      S_SPAWN_LK,
      S_SPAWN
   } state_t;

   state_t             r_state;
   logic [FLOOR_W-1:0] r_floor;
   logic [FLOOR_W-1:0] r_map_load_floor;
   logic               r_map_load_req;
   logic               r_dir_up;
   logic               r_tp;
   logic [COORD_W-1:0] r_px;
   logic [COORD_W-1:0] r_py;
   logic               r_spawn_valid;
   logic [COORD_W-1:0] r_spawn_x;
   logic [COORD_W-1:0] r_spawn_y;
   logic               r_busy;

   logic w_up_abs;
   logic w_dn_abs;
   logic w_up_hit;
   logic w_dn_hit;

   // A (0,0) lookup pair means the stair does not exist on that floor.
   assign w_up_abs = (lk_up_x == '0) && (lk_up_y == '0);
   assign w_dn_abs = (lk_down_x == '0) && (lk_down_y == '0);
   assign w_up_hit = !w_up_abs && (r_px == lk_up_x) && (r_py == lk_up_y) && (r_floor < LP_TOP);
   assign w_dn_hit = !w_dn_abs && (r_px == lk_down_x) && (r_py == lk_down_y) && (r_floor != '0);

   assign lookup_floor   = (r_state == S_IDLE || r_state == S_CHECK) ? r_floor : r_map_load_floor;
   assign map_load_req   = r_map_load_req;
   assign map_load_floor = r_map_load_floor;
   assign floor          = r_floor;
   assign spawn_valid    = r_spawn_valid;
   assign spawn_x        = r_spawn_x;
   assign spawn_y        = r_spawn_y;
   assign busy           = r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state          <= S_IDLE;
         r_floor          <= '0;
         r_map_load_floor <= '0;
         r_map_load_req   <= 1'b0;
         r_dir_up         <= 1'b0;
         r_tp             <= 1'b0;
         r_px             <= '0;
         r_py             <= '0;
         r_spawn_valid    <= 1'b0;
         r_spawn_x        <= '0;
         r_spawn_y        <= '0;
         r_busy           <= 1'b0;
      end else begin
         r_spawn_valid <= 1'b0;
         case (r_state)
            S_IDLE: begin
`ifdef FLOOR_TP_EN
               if (tp_valid) begin
                  if (tp_floor < LP_NUM && tp_floor != r_floor) begin
                     r_map_load_floor <= tp_floor;
                     r_dir_up         <= 1'b1;
                     r_tp             <= 1'b1;
                     r_map_load_req   <= 1'b1;
                     r_busy           <= 1'b1;
                     r_state          <= S_LOAD;
                  end
               end else
`endif
               if (step_valid) begin
                  r_px    <= player_x;
                  r_py    <= player_y;
                  r_tp    <= 1'b0;
                  r_busy  <= 1'b1;
                  r_state <= S_CHECK;
               end
            end
            S_CHECK: begin
               // Up wins when both stairs share the stepped-on tile.
               if (w_up_hit) begin
                  r_map_load_floor <= r_floor + 1'b1;
                  r_dir_up         <= 1'b1;
                  r_map_load_req   <= 1'b1;
                  r_state          <= S_LOAD;
               end else if (w_dn_hit) begin
                  r_map_load_floor <= r_floor - 1'b1;
                  r_dir_up         <= 1'b0;
                  r_map_load_req   <= 1'b1;
                  r_state          <= S_LOAD;
               end else begin
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_LOAD: begin
               if (map_load_done) begin
                  r_floor        <= r_map_load_floor;
                  r_map_load_req <= 1'b0;
                  r_state        <= S_SPAWN_LK;
               end
            end
            S_SPAWN_LK: begin
               // Arrive on the stair leading back where the player came from.
               if (!r_dir_up || (r_tp && w_dn_abs)) begin
                  r_spawn_x <= lk_up_x;
                  r_spawn_y <= lk_up_y;
               end else begin
                  r_spawn_x <= lk_down_x;
                  r_spawn_y <= lk_down_y;
               end
               r_spawn_valid <= 1'b1;
               r_state       <= S_SPAWN;
            end
            S_SPAWN: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_floor_switch_ctrl.sv
// Randomized floor-change bench against a stair-table reference model.
module tb_floor_switch_ctrl;
   localparam int NF = 2;
   localparam int FW = 16;
   localparam int CW = 4;

   // Level data: floor 0 has only an up stair, floor 1 only a down stair.
   localparam int UPX[NF] = '{2, 0};
   localparam int UPY[NF] = '{11, 0};
   localparam int DNX[NF] = '{0, 2};
   localparam int DNY[NF] = '{0, 1};

   logic          clk = 1'b0;
   logic          rst_n;
   logic          step_valid;
   logic [CW-1:0] player_x, player_y;
   logic [FW-1:0] lookup_floor;
   logic [CW-1:0] lk_down_x, lk_down_y, lk_up_x, lk_up_y;
   logic          map_load_req;
   logic [FW-1:0] map_load_floor;
   logic          map_load_done;
   logic [FW-1:0] floor;
   logic          spawn_valid;
   logic [CW-1:0] spawn_x, spawn_y;
   logic          busy;
`ifdef FLOOR_TP_EN
   logic          tp_valid;
   logic [FW-1:0] tp_floor;
`endif

   int checks = 0;
   int failures = 0;
   int m_floor = 0;

   always #5 clk = ~clk;

   always_comb begin
      lk_up_x = '0; lk_up_y = '0; lk_down_x = '0; lk_down_y = '0;
      for (int f = 0; f < NF; f++) begin
         if (lookup_floor == FW'(f)) begin
            lk_up_x   = CW'(UPX[f]);
            lk_up_y   = CW'(UPY[f]);
            lk_down_x = CW'(DNX[f]);
            lk_down_y = CW'(DNY[f]);
         end
      end
   end

   floor_switch_ctrl #(.NUM_FLOORS(NF), .FLOOR_W(FW), .COORD_W(CW)) dut (
      .clk(clk), .rst_n(rst_n),
      .step_valid(step_valid), .player_x(player_x), .player_y(player_y),
      .lookup_floor(lookup_floor),
      .lk_down_x(lk_down_x), .lk_down_y(lk_down_y), .lk_up_x(lk_up_x), .lk_up_y(lk_up_y),
      .map_load_req(map_load_req), .map_load_floor(map_load_floor), .map_load_done(map_load_done),
`ifdef FLOOR_TP_EN
      .tp_valid(tp_valid), .tp_floor(tp_floor),
`endif
      .floor(floor), .spawn_valid(spawn_valid), .spawn_x(spawn_x), .spawn_y(spawn_y),
      .busy(busy)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Called at the negedge after the edge that entered LOAD.
   task automatic do_load(input int tgt, input int sx, input int sy, input int nd, input bit stray);
      for (int i = 0; i < nd; i++) begin
         map_load_done = 1'b0;
         if (stray && i == 0) begin
            step_valid = 1'b1;
            player_x = CW'(UPX[m_floor]);
            player_y = CW'(UPY[m_floor]);
         end
         @(negedge clk);
         step_valid = 1'b0;
         chk("load_hold_req", map_load_req, 1);
         chk("load_hold_floor", floor, m_floor);
      end
      map_load_done = 1'b1;
      @(negedge clk);
      map_load_done = stray;
      chk("done_floor", floor, tgt);
      chk("done_req", map_load_req, 0);
      chk("done_spawn_early", spawn_valid, 0);
      chk("done_busy", busy, 1);
      @(negedge clk);
      map_load_done = 1'b0;
      chk("spawn_valid", spawn_valid, 1);
      chk("spawn_x", spawn_x, sx);
      chk("spawn_y", spawn_y, sy);
      chk("arrival_present", (spawn_x != 0 || spawn_y != 0), 1);
      @(negedge clk);
      chk("spawn_once", spawn_valid, 0);
      chk("end_busy", busy, 0);
      chk("spawn_x_hold", spawn_x, sx);
      chk("end_floor", floor, tgt);
      m_floor = tgt;
   endtask

   task automatic do_step(input int x, input int y, input int nd, input bit stray);
      bit load = 0, up = 0;
      int tgt = m_floor, sx = 0, sy = 0;
      if (x == UPX[m_floor] && y == UPY[m_floor] && !(UPX[m_floor] == 0 && UPY[m_floor] == 0)
          && m_floor < NF - 1) begin
         load = 1; up = 1; tgt = m_floor + 1;
      end else if (x == DNX[m_floor] && y == DNY[m_floor] && !(DNX[m_floor] == 0 && DNY[m_floor] == 0)
                   && m_floor > 0) begin
         load = 1; tgt = m_floor - 1;
      end
      if (load) begin
         sx = up ? DNX[tgt] : UPX[tgt];
         sy = up ? DNY[tgt] : UPY[tgt];
      end
      chk("idle_lookup", lookup_floor, m_floor);
      step_valid = 1'b1; player_x = CW'(x); player_y = CW'(y);
      @(negedge clk);
      step_valid = 1'b0; player_x = CW'($urandom); player_y = CW'($urandom);
      chk("check_busy", busy, 1);
      chk("check_req", map_load_req, 0);
      @(negedge clk);
      if (!load) begin
         chk("nostair_busy", busy, 0);
         chk("nostair_req", map_load_req, 0);
         chk("nostair_floor", floor, m_floor);
         return;
      end
      chk("load_req", map_load_req, 1);
      chk("load_floor", map_load_floor, tgt);
      chk("load_lookup", lookup_floor, tgt);
      do_load(tgt, sx, sy, nd, stray);
   endtask

`ifdef FLOOR_TP_EN
   task automatic do_tp(input int f, input int nd);
      bit ok = (f < NF) && (f != m_floor);
      int sx = 0, sy = 0;
      if (ok) begin
         sx = (DNX[f] == 0 && DNY[f] == 0) ? UPX[f] : DNX[f];
         sy = (DNX[f] == 0 && DNY[f] == 0) ? UPY[f] : DNY[f];
      end
      tp_valid = 1'b1; tp_floor = FW'(f);
      @(negedge clk);
      tp_valid = 1'b0;
      if (!ok) begin
         chk("tp_ignored_busy", busy, 0);
         chk("tp_ignored_req", map_load_req, 0);
         return;
      end
      chk("tp_req", map_load_req, 1);
      chk("tp_floor", map_load_floor, f);
      do_load(f, sx, sy, nd, 1'b0);
   endtask
`endif

   initial begin
      rst_n = 1'b0; step_valid = 1'b0; player_x = '0; player_y = '0; map_load_done = 1'b0;
`ifdef FLOOR_TP_EN
      tp_valid = 1'b0; tp_floor = '0;
`endif
      repeat (3) @(negedge clk);
      chk("rst_floor", floor, 0);
      chk("rst_busy", busy, 0);
      chk("rst_req", map_load_req, 0);
      chk("rst_spawn", spawn_valid, 0);
      chk("rst_spawn_xy", {spawn_x, spawn_y}, 0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_busy", busy, 0);

      do_step(2, 11, 5, 1'b0);   // up to floor 1
      do_step(2, 1, 2, 1'b1);    // down to floor 0, stray inputs
      do_step(0, 0, 0, 1'b0);    // floor 0: absent down stair
      do_step(2, 11, 0, 1'b0);
      do_step(0, 0, 0, 1'b0);    // top floor: absent up stair
      do_step(5, 5, 0, 1'b0);

      for (int it = 0; it < 40; it++) begin
         int sel = $urandom_range(0, 3);
         int x, y;
         if ($urandom_range(0, 3) == 0) begin
            map_load_done = 1'b1;
            @(negedge clk);
            map_load_done = 1'b0;
            chk("idle_done_ignored", floor, m_floor);
         end
         case (sel)
            0: begin x = UPX[m_floor]; y = UPY[m_floor]; end
            1: begin x = DNX[m_floor]; y = DNY[m_floor]; end
            2: begin x = 0; y = 0; end
            default: begin x = $urandom_range(0, 15); y = $urandom_range(0, 15); end
         endcase
         do_step(x, y, $urandom_range(0, 6), 1'($urandom_range(0, 1)));
      end

      // Reset in the middle of LOAD must abort without a spawn.
      if (m_floor == 0) begin player_x = 4'd2; player_y = 4'd11; end
      else begin player_x = 4'd2; player_y = 4'd1; end
      step_valid = 1'b1;
      @(negedge clk);
      step_valid = 1'b0;
      @(negedge clk);
      chk("pre_abort_req", map_load_req, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("abort_floor", floor, 0);
      chk("abort_req", map_load_req, 0);
      chk("abort_busy", busy, 0);
      chk("abort_load_floor", map_load_floor, 0);
      @(negedge clk);
      rst_n = 1'b1;
      m_floor = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("abort_no_spawn", spawn_valid, 0);
         chk("abort_idle", busy, 0);
      end

`ifdef FLOOR_TP_EN
      if (m_floor == 0) do_step(2, 11, 1, 1'b0);
      do_tp(0, 3);      // arrives on floor 0's up stair, its down stair is absent
      do_tp(2, 0);      // out of range
      do_tp(0, 0);      // already on that floor
      do_tp(1, 1);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
